// File: rtl/vector_out_collect_if.sv
// Handshake bundle between the systolic-array drain, the vector collector and the tile consumer.
// The master side is the producer/consumer pair; the slave side is the collector.
interface vector_out_collect_if #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(DIM + 1);

    logic                                  vec_valid;
    logic [DIM-1:0][WIDTH-1:0]             vec_in;
    logic                                  vec_ready;
    logic [IDX_W-1:0]                      index;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    out;
    logic                                  out_valid;
    logic                                  out_ready;

    modport master (
        output vec_valid,
        output vec_in,
        output out_ready,
        input  vec_ready,
        input  index,
        input  out,
        input  out_valid
    );

    modport slave (
        input  vec_valid,
        input  vec_in,
        input  out_ready,
        output vec_ready,
        output index,
        output out,
        output out_valid
    );
endinterface

// File: rtl/vector_out_collect.sv
// Collects DIM result vectors into a DIM x DIM tile (row- or column-wise) and hands the
// completed tile to the consumer over a valid/ready handshake.
module vector_out_collect #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter bit ROW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    vector_out_collect_if.slave  bus
);
    localparam int IDX_W = $clog2(DIM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] index_reg;
    logic [IDX_W-1:0] index_next;
    logic             beat_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= COLLECT;
            index_reg <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    // clear outranks both the beat write and the consumer handshake
    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        beat_accept = 1'b0;
        if (clear) begin
            state_next = COLLECT;
            index_next = '0;
        end else begin
            unique case (state_reg)
                COLLECT: begin
                    if (bus.vec_valid) begin
                        beat_accept = 1'b1;
                        index_next  = index_reg + 1'b1;
                        if (index_reg == LAST_IDX) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_next = COLLECT;
                        index_next = '0;
                    end
                end
                default: begin
                    state_next = COLLECT;
                    index_next = '0;
                end
            endcase
        end
    end

    // Handshake outputs come from state alone, never from the incoming valid/ready.
    assign bus.vec_ready = (state_reg == COLLECT);
    assign bus.out_valid = (state_reg == FULL);
    assign bus.index     = index_reg;

    // One register per matrix element; its write strobe is the beat number that targets it.
    genvar gi, gj;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_row
            for (gj = 0; gj < DIM; gj++) begin : g_col
                logic             write_sel;
                logic [WIDTH-1:0] elem_next;
                logic [WIDTH-1:0] elem_reg;

                if (ROW) begin : g_row_mode
                    assign write_sel = (index_reg == IDX_W'(gi));
                    assign elem_next = bus.vec_in[gj];
                end else begin : g_col_mode
                    assign write_sel = (index_reg == IDX_W'(gj));
                    assign elem_next = bus.vec_in[gi];
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        elem_reg <= '0;
                    end else if (clear) begin
                        elem_reg <= '0;
                    end else if (beat_accept && write_sel) begin
                        elem_reg <= elem_next;
                    end
                end

                assign bus.out[gi][gj] = elem_reg;
            end
        end
    endgenerate
endmodule

// File: tb/tb_vector_out_collect.sv
// Exercises a row-mode and a column-mode collector side by side with identical stimulus.
module tb_vector_out_collect;
    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mat_t;
    typedef struct {
        mat_t r;
        mat_t c;
    } tile_t;
    typedef struct {
        logic [31:0] vec;
        logic [2:0]  exp_index;
        logic        exp_ready;
        logic        exp_valid;
    } vec_rec_t;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      clear = 1'b0;
    logic                      vec_valid = 1'b0;
    logic                      out_ready = 1'b0;
    logic [DIM-1:0][WIDTH-1:0] vec_in = '0;

    int    checks = 0;
    int    errors = 0;
    tile_t sb_q[$];
    mat_t  exp_r = '0;
    mat_t  exp_c = '0;
    int    m_idx = 0;
    vec_rec_t tbl[4];

    always #5 clk = ~clk;

    vector_out_collect_if #(.DIM(DIM), .WIDTH(WIDTH)) bus_r ();
    vector_out_collect_if #(.DIM(DIM), .WIDTH(WIDTH)) bus_c ();

    assign bus_r.vec_valid = vec_valid;
    assign bus_r.vec_in    = vec_in;
    assign bus_r.out_ready = out_ready;
    assign bus_c.vec_valid = vec_valid;
    assign bus_c.vec_in    = vec_in;
    assign bus_c.out_ready = out_ready;

    vector_out_collect #(.DIM(DIM), .WIDTH(WIDTH), .ROW(1'b1)) dut_r (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus_r.slave)
    );

    vector_out_collect #(.DIM(DIM), .WIDTH(WIDTH), .ROW(1'b0)) dut_c (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus_c.slave)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s ok value=%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string name, input int idx, input logic rdy, input logic vld);
        chk({name, "_idx_r"}, 128'(bus_r.index), 128'(idx));
        chk({name, "_idx_c"}, 128'(bus_c.index), 128'(idx));
        chk({name, "_rdy_r"}, 128'(bus_r.vec_ready), 128'(rdy));
        chk({name, "_rdy_c"}, 128'(bus_c.vec_ready), 128'(rdy));
        chk({name, "_vld_r"}, 128'(bus_r.out_valid), 128'(vld));
        chk({name, "_vld_c"}, 128'(bus_c.out_valid), 128'(vld));
    endtask

    task automatic model_reset();
        exp_r = '0;
        exp_c = '0;
        m_idx = 0;
    endtask

    // Drive one accepted beat; the expected tile is queued once the model sees DIM beats.
    task automatic drive_beat(input logic [31:0] v);
        vec_valid = 1'b1;
        vec_in    = v;
        exp_r[m_idx] = v;
        for (int i = 0; i < DIM; i++) exp_c[i][m_idx] = v[i*8 +: 8];
        m_idx++;
        if (m_idx == DIM) sb_q.push_back('{r: exp_r, c: exp_c});
        step();
        vec_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        tile_t e;
        t = 0;
        while (!bus_r.out_valid && t < 20) begin
            step();
            t++;
        end
        if (!bus_r.out_valid || sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=valid%0b/queued%0d required=valid1/queued1",
                     name, bus_r.out_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            chk({name, "_mat_r"}, bus_r.out, e.r);
            chk({name, "_mat_c"}, bus_c.out, e.c);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check_status({name, "_rearm"}, 0, 1'b1, 1'b0);
        end
        m_idx = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tile_t front;
        logic [7:0] ev;
        tbl[0] = '{vec: 32'h03020100, exp_index: 3'd1, exp_ready: 1'b1, exp_valid: 1'b0};
        tbl[1] = '{vec: 32'h13121110, exp_index: 3'd2, exp_ready: 1'b1, exp_valid: 1'b0};
        tbl[2] = '{vec: 32'h23222120, exp_index: 3'd3, exp_ready: 1'b1, exp_valid: 1'b0};
        tbl[3] = '{vec: 32'h33323130, exp_index: 3'd4, exp_ready: 1'b0, exp_valid: 1'b1};

        // Reset state
        #12;
        check_status("in_reset", 0, 1'b1, 1'b0);
        chk("in_reset_out_r", bus_r.out, '0);
        chk("in_reset_out_c", bus_c.out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_status("post_reset", 0, 1'b1, 1'b0);

        // Back-to-back tile with out_ready low
        for (int k = 0; k < DIM; k++) begin
            drive_beat(tbl[k].vec);
            check_status($sformatf("tbl%0d", k), int'(tbl[k].exp_index),
                         tbl[k].exp_ready, tbl[k].exp_valid);
        end
        for (int k = 0; k < DIM; k++) begin
            for (int i = 0; i < DIM; i++) begin
                ev = 8'(k * 16 + i);
                chk($sformatf("row_out%0d%0d", k, i), 128'(bus_r.out[k][i]), 128'(ev));
                chk($sformatf("col_out%0d%0d", i, k), 128'(bus_c.out[i][k]), 128'(ev));
            end
        end

        // Hold in FULL while a producer keeps pushing 0xFF
        front = sb_q[0];
        vec_valid = 1'b1;
        vec_in    = 32'hFFFFFFFF;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("hold%0d_idx", c), 128'(bus_r.index), 128'd4);
            chk($sformatf("hold%0d_vld", c), 128'(bus_c.out_valid), 128'd1);
            chk($sformatf("hold%0d_mat_r", c), bus_r.out, front.r);
            chk($sformatf("hold%0d_mat_c", c), bus_c.out, front.c);
        end
        out_ready = 1'b1;
        front = sb_q.pop_front();
        chk("handshake_mat_r", bus_r.out, front.r);
        chk("handshake_mat_c", bus_c.out, front.c);
        step();
        out_ready = 1'b0;
        check_status("after_pulse", 0, 1'b1, 1'b0);
        chk("after_pulse_mat_r", bus_r.out, front.r);
        chk("after_pulse_mat_c", bus_c.out, front.c);
        vec_valid = 1'b0;
        m_idx = 0;

        // Tile with random gaps between beats
        for (int k = 0; k < DIM; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            vec_valid = 1'b0;
            vec_in    = 32'hDEADBEEF;
            for (int g = 0; g < gap; g++) begin
                step();
                chk($sformatf("gap%0d_%0d_idx", k, g), 128'(bus_c.index), 128'(k));
            end
            drive_beat(tbl[k].vec);
            chk($sformatf("gap%0d_beat_idx", k), 128'(bus_r.index), 128'(k + 1));
        end
        drain("gap");

        // clear after two beats discards the partial tile and a coincident beat
        drive_beat($urandom);
        drive_beat($urandom);
        check_status("pre_clear", 2, 1'b1, 1'b0);
        clear     = 1'b1;
        vec_valid = 1'b1;
        vec_in    = $urandom;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        vec_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        check_status("clear", 0, 1'b1, 1'b0);
        chk("clear_out_r", bus_r.out, '0);
        chk("clear_out_c", bus_c.out, '0);
        for (int k = 0; k < DIM; k++) drive_beat($urandom);
        drain("post_clear");

        // Asynchronous reset in the middle of a tile
        for (int k = 0; k < 3; k++) drive_beat($urandom);
        check_status("pre_areset", 3, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_status("areset", 0, 1'b1, 1'b0);
        chk("areset_out_r", bus_r.out, '0);
        chk("areset_out_c", bus_c.out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_status("areset_release", 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
